// File: rtl/sorted_pkg.sv
// Shared defaults, FSM encoding and counter widths for the sorted-array builder
// that feeds the binary-search datapath.
package sorted_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int AW_DEF     = 5;
  localparam int DW_DEF     = 8;
  localparam int SWAP_CNT_W = 10;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_SORT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare/swap cell: orders one adjacent pair, unsigned, and
// reports whether the pair had to be exchanged (equal words stay put).
module sort_cmp_swap #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi,
  output logic          swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sorted_array_builder.sv
// Loads DEPTH bytes, bubble-sorts them in place one compare/swap per cycle,
// then serves them through a registered read port gated by done.
module sorted_array_builder
  import sorted_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rs,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  in_ready,
  output logic                  done,
  input  logic [AW-1:0]         rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_cnt, idx, last;
  logic [AW-1:0] idx_nxt;
  logic          swapped;
  logic          accept, pass_end, sort_finish;
  logic [DW-1:0] cmp_lo, cmp_hi;
  logic          cmp_swap;

  assign in_ready = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);
  // clear takes priority over a word offered in the same cycle
  assign accept   = in_valid & in_ready & ~clear;

  assign idx_nxt     = idx + ONE;
  assign pass_end    = (idx == last - ONE);
  assign sort_finish = pass_end && (!(swapped || cmp_swap) || last == ONE);

  sort_cmp_swap #(.DW(DW)) u_cmp (
    .a    (mem[idx]),
    .b    (mem[idx_nxt]),
    .lo   (cmp_lo),
    .hi   (cmp_hi),
    .swap (cmp_swap)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_d; no latch is inferred.
    state_d = state_q;
    if (clear) begin
      state_d = ST_LOAD;
    end else begin
      unique case (state_q)
        ST_LOAD: if (accept && wr_cnt == LAST_ADDR) state_d = ST_SORT;
        ST_SORT: if (sort_finish) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      wr_cnt   <= '0;
      idx      <= '0;
      last     <= '0;
      swapped  <= 1'b0;
      swap_cnt <= '0;
    end else if (clear) begin
      wr_cnt   <= '0;
      idx      <= '0;
      swapped  <= 1'b0;
      swap_cnt <= '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (accept) begin
            wr_cnt <= wr_cnt + ONE;
            if (wr_cnt == LAST_ADDR) begin
              idx      <= '0;
              last     <= LAST_ADDR;
              swapped  <= 1'b0;
              swap_cnt <= '0;
            end
          end
        end
        ST_SORT: begin
          if (cmp_swap && swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
          if (pass_end) begin
            idx     <= '0;
            last    <= last - ONE;
            swapped <= 1'b0;
          end else begin
            idx     <= idx_nxt;
            swapped <= swapped | cmp_swap;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array is a flop array, not a RAM macro, so it is reset to zero;
  // a fresh start must never expose a previous load.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wr_cnt] <= in_data;
    end else if (state_q == ST_SORT && !clear && cmp_swap) begin
      mem[idx]     <= cmp_lo;
      mem[idx_nxt] <= cmp_hi;
    end
  end

  // Same address->q timing as the searcher's memory: one cycle, any state.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_sorted_array_builder.sv
// Scoreboarded bench for sorted_array_builder: directed loads, sort-length and
// swap-count checks, and registered read-back compared by a separate monitor.
module tb_sorted_array_builder;
  import sorted_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

  typedef logic [DW-1:0] arr_t [DEPTH];

  logic                  clk = 1'b0;
  logic                  rs;
  logic                  clear;
  logic                  in_valid;
  logic [DW-1:0]         in_data;
  logic                  in_ready;
  logic                  done;
  logic [AW-1:0]         rd_addr;
  logic [DW-1:0]         rd_data;
  logic [SWAP_CNT_W-1:0] swap_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sb_q [$];
  logic          rd_req   = 1'b0;
  logic          rd_req_q = 1'b0;

  sorted_array_builder dut (
    .clk      (clk),
    .rs       (rs),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .swap_cnt (swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Read monitor: a request issued before edge n has its data visible after edge n.
  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    if (rd_req_q) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_underflow: read data with empty scoreboard at %0t", $time);
      end else begin
        check("rd_data", {24'b0, rd_data}, {24'b0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // All tasks start and end just after a falling edge.
  task automatic load_array(input arr_t v, input bit gaps);
    for (int k = 0; k < DEPTH; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[k];
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_sort(input string name, input int exp_cycles);
    int cyc = 0;
    check({name, "_entry_in_ready"}, {31'b0, in_ready}, 32'd0);
    while (!done && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    if (exp_cycles >= 0) check({name, "_sort_cycles"}, cyc, exp_cycles);
  endtask

  task automatic read_all(input arr_t exp);
    int t = 0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = AW'(k);
      rd_req  = 1'b1;
      sb_q.push_back(exp[k]);
      @(negedge clk);
    end
    rd_req = 1'b0;
    while (sb_q.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rd_drain: %0d expected reads never returned", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_clear(input string name);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check({name, "_clr_done"},     {31'b0, done},     32'd0);
    check({name, "_clr_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({name, "_clr_swap_cnt"}, {22'b0, swap_cnt}, 32'd0);
  endtask

  initial begin
    arr_t          v, e;
    logic [DW-1:0] q [$];

    rs = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_rd_data",  {24'b0, rd_data},  32'd0);
    check("rst_swap_cnt", {22'b0, swap_cnt}, 32'd0);
    rs = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: already ascending, one pass without swaps
    for (int k = 0; k < DEPTH; k++) v[k] = DW'(k);
    load_array(v, 1'b0);
    wait_sort("t1", 31);
    check("t1_swap_cnt", {22'b0, swap_cnt}, 32'd0);
    read_all(v);
    do_clear("t1");

    // 2: descending, worst case
    for (int k = 0; k < DEPTH; k++) begin v[k] = DW'(31 - k); e[k] = DW'(k); end
    load_array(v, 1'b0);
    wait_sort("t2", 496);
    check("t2_swap_cnt", {22'b0, swap_cnt}, 32'd496);
    read_all(e);
    do_clear("t2");

    // 3: one small word at addr 7 bubbles left; 7 swap passes + 1 clean pass
    for (int k = 0; k < DEPTH; k++) begin v[k] = 8'hA5; e[k] = 8'hA5; end
    v[7] = 8'h00;
    e[0] = 8'h00;
    load_array(v, 1'b0);
    wait_sort("t3", 31 + 30 + 29 + 28 + 27 + 26 + 25 + 24);
    check("t3_swap_cnt", {22'b0, swap_cnt}, 32'd7);
    read_all(e);
    do_clear("t3");

    // 4: random bytes with gaps; in_valid in DONE must be ignored
    q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      v[k] = DW'($urandom_range(0, 255));
      q.push_back(v[k]);
    end
    q.sort();
    for (int k = 0; k < DEPTH; k++) e[k] = q[k];
    load_array(v, 1'b1);
    wait_sort("t4", -1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check("t4_done_in_ready", {31'b0, in_ready}, 32'd0);
      check("t4_done_hold",     {31'b0, done},     32'd1);
    end
    in_valid = 1'b0;
    read_all(e);
    do_clear("t4");

    // 5: clear after 10 words (clear beats a concurrent word), then full reload
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(negedge clk);
    end
    in_data = 8'h01;
    do_clear("t5");
    in_valid = 1'b0;
    q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      v[k] = DW'(k * 7 + 3);
      q.push_back(v[k]);
    end
    q.sort();
    for (int k = 0; k < DEPTH; k++) e[k] = q[k];
    load_array(v, 1'b0);
    wait_sort("t5", -1);
    read_all(e);
    do_clear("t5b");

    // clear mid-sort aborts back to LOAD
    for (int k = 0; k < DEPTH; k++) v[k] = DW'(31 - k);
    load_array(v, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_busy", {31'b0, in_ready}, 32'd0);
    do_clear("abort");

    // 6: async reset in the middle of a long sort
    load_array(v, 1'b0);
    repeat (99) @(negedge clk);
    check("t6_pre_done", {31'b0, done}, 32'd0);
    rs = 1'b0;
    #1;
    check("t6_rst_done",     {31'b0, done},     32'd0);
    check("t6_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("t6_rst_rd_data",  {24'b0, rd_data},  32'd0);
    check("t6_rst_swap_cnt", {22'b0, swap_cnt}, 32'd0);
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);
    check("t6_rel_in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < DEPTH; k++) e[k] = '0;
    read_all(e);
    for (int k = 0; k < DEPTH; k++) begin v[k] = DW'((k * 13) % 32); e[k] = DW'(k); end
    load_array(v, 1'b0);
    wait_sort("t6", -1);
    read_all(e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
